// File: rtl/embedding_stream_lookup_if.sv
`default_nettype none
// ============================================================================
// Module      : embedding_stream_lookup_if
// Description : Table-load, lookup-request and beat-stream bundle for the
//               streaming token+position embedding lookup.
// Revision    : 1.0 - initial release
// ============================================================================
interface embedding_stream_lookup_if #(
  parameter int VOCAB_SIZE  = 16,
  parameter int MAX_SEQ_LEN = 8,
  parameter int EMBED_DIM   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 2
);
  localparam int TAW = $clog2(VOCAB_SIZE);
  localparam int PAW = $clog2(MAX_SEQ_LEN);
  localparam int DAW = $clog2(EMBED_DIM);

  logic                        load_en;
  logic                        load_sel;
  logic [TAW-1:0]              load_row;
  logic [DAW-1:0]              load_dim;
  logic [DATA_WIDTH-1:0]       load_data;
  logic                        in_valid;
  logic                        in_ready;
  logic [TAW-1:0]              token_id;
  logic [PAW-1:0]              position;
  logic                        pos_mode;
  logic                        seq_clear;
  logic                        out_valid;
  logic                        out_ready;
  logic [LANES*DATA_WIDTH-1:0] out_data;
  logic                        out_last;
  logic                        out_oob;
  logic                        out_sat;
  logic [PAW-1:0]              pos_cnt;

  modport master (
    output load_en, load_sel, load_row, load_dim, load_data,
    output in_valid, token_id, position, pos_mode, seq_clear, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_oob, out_sat, pos_cnt
  );

  modport slave (
    input  load_en, load_sel, load_row, load_dim, load_data,
    input  in_valid, token_id, position, pos_mode, seq_clear, out_ready,
    output in_ready, out_valid, out_data, out_last, out_oob, out_sat, pos_cnt
  );
endinterface
`default_nettype wire

// File: rtl/embedding_stream_lookup.sv
`default_nettype none
// ============================================================================
// Module      : embedding_stream_lookup
// Description : Token+position embedding lookup with saturating add, range
//               detection and LANES-wide beat streaming with backpressure.
// Revision    : 1.0 - initial release
// ============================================================================
module embedding_stream_lookup #(
  parameter int VOCAB_SIZE  = 16,
  parameter int MAX_SEQ_LEN = 8,
  parameter int EMBED_DIM   = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int LANES       = 2
) (
  input  wire logic                clk,
  input  wire logic                rst,
  embedding_stream_lookup_if.slave bus
);
  localparam int TAW   = $clog2(VOCAB_SIZE);
  localparam int PAW   = $clog2(MAX_SEQ_LEN);
  localparam int DAW   = $clog2(EMBED_DIM);
  localparam int BEATS = EMBED_DIM / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [DATA_WIDTH-1:0] c_max = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] c_min = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0] r_tok_tab [VOCAB_SIZE][EMBED_DIM];
  logic [DATA_WIDTH-1:0] r_pos_tab [MAX_SEQ_LEN][EMBED_DIM];

  logic [TAW-1:0]              r_tok_id;
  logic [PAW-1:0]              r_pos_id;
  logic                        r_tok_oob;
  logic                        r_pos_oob;
  logic [BW-1:0]               r_beat;
  logic [PAW-1:0]              r_pos_cnt;
  logic                        r_out_valid;
  logic                        r_out_last;
  logic                        r_out_oob;
  logic                        r_out_sat;
  logic [LANES*DATA_WIDTH-1:0] r_out_data;

  logic                        w_in_ready;
  logic                        w_accept;
  logic                        w_load_fire;
  logic                        w_beat_load;
  logic                        w_last_hs;
  logic [BW-1:0]               w_calc_beat;
  logic [LANES*DATA_WIDTH-1:0] w_beat_data;
  logic [LANES-1:0]            w_lane_sat;
  logic                        w_beat_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_beat_load = 1'b0;
    w_last_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !rst && !bus.load_en;
        if (bus.in_valid && w_in_ready) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_beat_load = 1'b1;
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (bus.out_ready) begin
          if (r_out_last) begin
            w_last_hs   = 1'b1;
            w_state_nxt = S_IDLE;
          end else begin
            w_beat_load = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_accept    = bus.in_valid && w_in_ready;
  assign w_load_fire = (r_state == S_IDLE) && bus.load_en;

  // The beat being registered: beat 0 in FETCH, otherwise the one after the current.
  assign w_calc_beat = (r_state == S_FETCH) ? '0 : r_beat + BW'(1);
  assign w_beat_last = (w_calc_beat == BW'(BEATS - 1));

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [DAW-1:0]        w_elem;
    logic [DATA_WIDTH-1:0] w_tok_v;
    logic [DATA_WIDTH-1:0] w_pos_v;
    logic [DATA_WIDTH:0]   w_sum;
    logic                  w_clamp;

    assign w_elem  = DAW'(int'(w_calc_beat) * LANES + gi);
    assign w_tok_v = r_tok_oob ? '0 : r_tok_tab[r_tok_id][w_elem];
    assign w_pos_v = r_pos_oob ? '0 : r_pos_tab[r_pos_id][w_elem];
    assign w_sum   = {w_tok_v[DATA_WIDTH-1], w_tok_v} + {w_pos_v[DATA_WIDTH-1], w_pos_v};
    // Overflow when the extra sign bit disagrees with the result's sign bit.
    assign w_clamp = w_sum[DATA_WIDTH] != w_sum[DATA_WIDTH-1];
    assign w_beat_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      w_clamp ? (w_sum[DATA_WIDTH] ? c_min : c_max) : w_sum[DATA_WIDTH-1:0];
    assign w_lane_sat[gi] = w_clamp;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < VOCAB_SIZE; r++)
        for (int d = 0; d < EMBED_DIM; d++) r_tok_tab[r][d] <= '0;
      for (int r = 0; r < MAX_SEQ_LEN; r++)
        for (int d = 0; d < EMBED_DIM; d++) r_pos_tab[r][d] <= '0;
      r_tok_id    <= '0;
      r_pos_id    <= '0;
      r_tok_oob   <= 1'b0;
      r_pos_oob   <= 1'b0;
      r_beat      <= '0;
      r_pos_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_oob   <= 1'b0;
      r_out_sat   <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_load_fire && int'(bus.load_dim) < EMBED_DIM) begin
        if (!bus.load_sel) begin
          if (int'(bus.load_row) < VOCAB_SIZE)
            r_tok_tab[bus.load_row][bus.load_dim] <= bus.load_data;
        end else begin
          if (int'(bus.load_row) < MAX_SEQ_LEN)
            r_pos_tab[bus.load_row[PAW-1:0]][bus.load_dim] <= bus.load_data;
        end
      end

      if (w_accept) begin
        r_tok_id  <= bus.token_id;
        r_pos_id  <= bus.pos_mode ? r_pos_cnt : bus.position;
        r_tok_oob <= int'(bus.token_id) >= VOCAB_SIZE;
        r_pos_oob <= !bus.pos_mode && (int'(bus.position) >= MAX_SEQ_LEN);
        r_beat    <= '0;
      end

      // Clear wins over the increment; a coincident accept already latched the old count.
      if (bus.seq_clear)
        r_pos_cnt <= '0;
      else if (w_accept && bus.pos_mode)
        r_pos_cnt <= (int'(r_pos_cnt) == MAX_SEQ_LEN - 1) ? '0 : r_pos_cnt + PAW'(1);

      if (w_beat_load) begin
        r_beat      <= w_calc_beat;
        r_out_data  <= w_beat_data;
        r_out_sat   <= |w_lane_sat;
        r_out_last  <= w_beat_last;
        r_out_oob   <= r_tok_oob || r_pos_oob;
        r_out_valid <= 1'b1;
      end else if (w_last_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.out_oob   = r_out_oob;
  assign bus.out_sat   = r_out_sat;
  assign bus.pos_cnt   = r_pos_cnt;
endmodule
`default_nettype wire

// File: tb/tb_embedding_stream_lookup.sv
`default_nettype none
// ============================================================================
// Module      : tb_embedding_stream_lookup
// Description : Directed bench with a vector-level reference model; instance
//               a uses defaults, instance b uses VOCAB_SIZE=12, MAX_SEQ_LEN=6.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_embedding_stream_lookup;
  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic        oob;
    logic        sat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  embedding_stream_lookup_if #(.VOCAB_SIZE(16), .MAX_SEQ_LEN(8), .EMBED_DIM(4),
    .DATA_WIDTH(16), .LANES(2)) ifa ();
  embedding_stream_lookup_if #(.VOCAB_SIZE(12), .MAX_SEQ_LEN(6), .EMBED_DIM(4),
    .DATA_WIDTH(16), .LANES(2)) ifb ();

  embedding_stream_lookup #(.VOCAB_SIZE(16), .MAX_SEQ_LEN(8), .EMBED_DIM(4),
    .DATA_WIDTH(16), .LANES(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  embedding_stream_lookup #(.VOCAB_SIZE(12), .MAX_SEQ_LEN(6), .EMBED_DIM(4),
    .DATA_WIDTH(16), .LANES(2)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  logic        d_load_en  [2];
  logic        d_load_sel [2];
  logic [3:0]  d_load_row [2];
  logic [1:0]  d_load_dim [2];
  logic [15:0] d_load_data[2];
  logic        d_in_valid [2];
  logic [3:0]  d_token_id [2];
  logic [2:0]  d_position [2];
  logic        d_pos_mode [2];
  logic        d_seq_clear[2];
  logic        d_out_ready[2];

  assign ifa.load_en   = d_load_en[0];   assign ifb.load_en   = d_load_en[1];
  assign ifa.load_sel  = d_load_sel[0];  assign ifb.load_sel  = d_load_sel[1];
  assign ifa.load_row  = d_load_row[0];  assign ifb.load_row  = d_load_row[1];
  assign ifa.load_dim  = d_load_dim[0];  assign ifb.load_dim  = d_load_dim[1];
  assign ifa.load_data = d_load_data[0]; assign ifb.load_data = d_load_data[1];
  assign ifa.in_valid  = d_in_valid[0];  assign ifb.in_valid  = d_in_valid[1];
  assign ifa.token_id  = d_token_id[0];  assign ifb.token_id  = d_token_id[1];
  assign ifa.position  = d_position[0];  assign ifb.position  = d_position[1];
  assign ifa.pos_mode  = d_pos_mode[0];  assign ifb.pos_mode  = d_pos_mode[1];
  assign ifa.seq_clear = d_seq_clear[0]; assign ifb.seq_clear = d_seq_clear[1];
  assign ifa.out_ready = d_out_ready[0]; assign ifb.out_ready = d_out_ready[1];

  int checks = 0;
  int errors = 0;

  // Reference model: tables as plain signed integers, expected beats as queues.
  int          tok_m [2][16][4];
  int          pos_m [2][8][4];
  int          pcnt_m[2];
  beat_t       q0[$];
  beat_t       q1[$];
  int          bidx[2];
  logic [31:0] cap_data[2][2];
  logic        cap_oob [2][2];
  logic        cap_sat [2][2];

  function automatic int voc(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic int msl(input int k);
    return (k == 0) ? 8 : 6;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < 16; r++) for (int d = 0; d < 4; d++) tok_m[k][r][d] = 0;
      for (int r = 0; r < 8; r++)  for (int d = 0; d < 4; d++) pos_m[k][r][d] = 0;
      pcnt_m[k] = 0;
      bidx[k]   = 0;
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic push_vec(input int k, input int t, input int p, input bit mode);
    int    pe;
    bit    toob, poob;
    int    s, tv, pv;
    beat_t b;
    pe   = mode ? pcnt_m[k] : p;
    toob = t >= voc(k);
    poob = pe >= msl(k);
    for (int bt = 0; bt < 2; bt++) begin
      b = '0;
      for (int ln = 0; ln < 2; ln++) begin
        tv = toob ? 0 : tok_m[k][t][bt*2+ln];
        pv = poob ? 0 : pos_m[k][pe][bt*2+ln];
        s  = tv + pv;
        if (s > 32767)  begin s = 32767;  b.sat = 1'b1; end
        if (s < -32768) begin s = -32768; b.sat = 1'b1; end
        b.data[ln*16 +: 16] = 16'(s);
      end
      b.last = (bt == 1);
      b.oob  = toob || poob;
      if (k == 0) q0.push_back(b); else q1.push_back(b);
    end
  endtask

  task automatic cmp_side(input int k, input logic v, input logic r, input logic [31:0] d,
                          input logic l, input logic o, input logic s);
    beat_t e;
    int    n;
    if (!v) return;
    n = (k == 0) ? q0.size() : q1.size();
    if (n == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_beat inst=%0d actual=%h required=no beat", k, d);
      return;
    end
    e = (k == 0) ? q0[0] : q1[0];
    chk($sformatf("beat_data_i%0d_b%0d", k, bidx[k]), d, e.data);
    chk($sformatf("beat_last_i%0d_b%0d", k, bidx[k]), 32'(l), 32'(e.last));
    chk($sformatf("beat_oob_i%0d_b%0d", k, bidx[k]), 32'(o), 32'(e.oob));
    chk($sformatf("beat_sat_i%0d_b%0d", k, bidx[k]), 32'(s), 32'(e.sat));
    if (r) begin
      if (k == 0) void'(q0.pop_front()); else void'(q1.pop_front());
      cap_data[k][bidx[k]] = d;
      cap_oob[k][bidx[k]]  = o;
      cap_sat[k][bidx[k]]  = s;
      bidx[k] = l ? 0 : 1;
    end
  endtask

  always @(negedge clk) begin
    cmp_side(0, ifa.out_valid, ifa.out_ready, ifa.out_data, ifa.out_last, ifa.out_oob, ifa.out_sat);
    cmp_side(1, ifb.out_valid, ifb.out_ready, ifb.out_data, ifb.out_last, ifb.out_oob, ifb.out_sat);
  end

  task automatic do_load(input int k, input bit sel, input int row, input int dim, input logic [15:0] data);
    d_load_en[k]   = 1'b1;
    d_load_sel[k]  = sel;
    d_load_row[k]  = 4'(row);
    d_load_dim[k]  = 2'(dim);
    d_load_data[k] = data;
    @(posedge clk);
    #1;
    d_load_en[k] = 1'b0;
    if (!sel && row < voc(k)) tok_m[k][row][dim] = int'($signed(data));
    if (sel && row < msl(k))  pos_m[k][row][dim] = int'($signed(data));
  endtask

  task automatic lookup(input int k, input int t, input int p, input bit mode, input bit clr);
    bit rdy;
    d_in_valid[k]  = 1'b1;
    d_token_id[k]  = 4'(t);
    d_position[k]  = 3'(p);
    d_pos_mode[k]  = mode;
    d_seq_clear[k] = clr;
    rdy = 1'b0;
    for (int i = 0; i < 50 && !rdy; i++) begin
      @(negedge clk);
      rdy = (k == 0) ? ifa.in_ready : ifb.in_ready;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d actual=in_ready low required=accept", k);
      d_in_valid[k]  = 1'b0;
      d_seq_clear[k] = 1'b0;
      return;
    end
    @(posedge clk);
    push_vec(k, t, p, mode);
    if (clr)       pcnt_m[k] = 0;
    else if (mode) pcnt_m[k] = (pcnt_m[k] + 1) % msl(k);
    #1;
    d_in_valid[k]  = 1'b0;
    d_seq_clear[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 1;
    for (int i = 0; i < 100 && n != 0; i++) begin
      @(negedge clk);
      n = (k == 0) ? q0.size() : q1.size();
    end
    if (n != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout inst=%0d actual=%0d pending required=0", k, n);
    end
    @(posedge clk);
    #1;
  endtask

  logic [31:0] snap;

  initial begin
    for (int k = 0; k < 2; k++) begin
      d_load_en[k] = 0; d_load_sel[k] = 0; d_load_row[k] = 0; d_load_dim[k] = 0;
      d_load_data[k] = 0; d_in_valid[k] = 0; d_token_id[k] = 0; d_position[k] = 0;
      d_pos_mode[k] = 0; d_seq_clear[k] = 0; d_out_ready[k] = 1;
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(ifa.out_valid), 0);
    chk("rst_in_ready", 32'(ifa.in_ready), 0);
    chk("rst_pos_cnt", 32'(ifa.pos_cnt), 0);
    chk("rst_out_data", ifa.out_data, 0);
    chk("rst_flags", {29'd0, ifa.out_last, ifa.out_oob, ifa.out_sat}, 0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(ifa.in_ready), 1);

    // Basic lookup with exact cycle timing.
    do_load(0, 0, 5, 0, 16'd256);  do_load(0, 0, 5, 1, 16'd512);
    do_load(0, 0, 5, 2, 16'd768);  do_load(0, 0, 5, 3, 16'd1024);
    do_load(0, 1, 2, 0, 16'd26);   do_load(0, 1, 2, 1, 16'd51);
    do_load(0, 1, 2, 2, 16'd77);   do_load(0, 1, 2, 3, 16'd102);
    lookup(0, 5, 2, 0, 0);
    chk("fetch_out_valid", 32'(ifa.out_valid), 0);
    @(posedge clk); #1;
    chk("basic_b0_valid", 32'(ifa.out_valid), 1);
    chk("basic_b0_data", ifa.out_data, 32'h0233_011A);
    chk("basic_b0_last", 32'(ifa.out_last), 0);
    chk("basic_b0_flags", {30'd0, ifa.out_oob, ifa.out_sat}, 0);
    @(posedge clk); #1;
    chk("basic_b1_data", ifa.out_data, 32'h0466_034D);
    chk("basic_b1_last", 32'(ifa.out_last), 1);
    @(posedge clk); #1;
    chk("basic_done_valid", 32'(ifa.out_valid), 0);
    chk("basic_done_in_ready", 32'(ifa.in_ready), 1);

    // Saturation in both directions on beat 0 only.
    do_load(0, 0, 7, 0, 16'h7F00); do_load(0, 0, 7, 1, 16'h8100);
    do_load(0, 1, 0, 0, 16'h0200); do_load(0, 1, 0, 1, 16'hFE00);
    lookup(0, 7, 0, 0, 0);
    wait_idle(0);
    chk("sat_b0_data", cap_data[0][0], 32'h8000_7FFF);
    chk("sat_b0_sat", 32'(cap_sat[0][0]), 1);
    chk("sat_b1_data", cap_data[0][1], 0);
    chk("sat_b1_sat", 32'(cap_sat[0][1]), 0);

    // Backpressure on beat 0 with a stray table write that must be ignored.
    d_out_ready[0] = 1'b0;
    lookup(0, 5, 2, 0, 0);
    @(posedge clk); #1;
    chk("bp_valid", 32'(ifa.out_valid), 1);
    snap = ifa.out_data;
    d_load_en[0] = 1'b1; d_load_sel[0] = 1'b0; d_load_row[0] = 4'd5;
    d_load_dim[0] = 2'd0; d_load_data[0] = 16'd999;
    repeat (3) begin
      @(posedge clk); #1;
      chk("bp_hold_data", ifa.out_data, snap);
      chk("bp_hold_last", 32'(ifa.out_last), 0);
      chk("bp_in_ready", 32'(ifa.in_ready), 0);
    end
    d_load_en[0]   = 1'b0;
    d_out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_b1_last", 32'(ifa.out_last), 1);
    chk("bp_b1_data", ifa.out_data, 32'h0466_034D);
    @(posedge clk); #1;
    chk("bp_done_valid", 32'(ifa.out_valid), 0);
    lookup(0, 5, 2, 0, 0);
    wait_idle(0);
    chk("bp_table_kept", cap_data[0][0], 32'h0233_011A);

    // Auto position with wrap, then clear coincident with an accept.
    for (int p = 0; p < 8; p++) do_load(0, 1, p, 0, 16'(p * 256));
    for (int i = 0; i < 9; i++) begin
      lookup(0, 0, 0, 1, 0);
      wait_idle(0);
      chk($sformatf("auto_dim0_%0d", i), {16'd0, cap_data[0][0][15:0]}, 32'((i % 8) * 256));
    end
    chk("auto_wrap_cnt", 32'(ifa.pos_cnt), 1);
    lookup(0, 0, 0, 1, 1);
    wait_idle(0);
    chk("auto_clr_dim0", {16'd0, cap_data[0][0][15:0]}, 32'd256);
    chk("auto_clr_cnt", 32'(ifa.pos_cnt), 0);
    lookup(0, 0, 3, 0, 0);
    wait_idle(0);
    chk("explicit_dim0", {16'd0, cap_data[0][0][15:0]}, 32'd768);
    chk("explicit_cnt", 32'(ifa.pos_cnt), 0);

    // A position-table write to row 9 is out of range and must not alias row 1.
    do_load(0, 1, 9, 0, 16'd1234);
    lookup(0, 0, 1, 0, 0);
    wait_idle(0);
    chk("oob_load_ignored", {16'd0, cap_data[0][0][15:0]}, 32'd256);

    // Out-of-range token and position on the small instance.
    do_load(1, 0, 2, 0, 16'd100); do_load(1, 0, 2, 1, 16'd200);
    do_load(1, 0, 2, 2, 16'd300); do_load(1, 0, 2, 3, 16'd400);
    do_load(1, 1, 3, 0, 16'd10);  do_load(1, 1, 3, 1, 16'd20);
    do_load(1, 1, 3, 2, 16'd30);  do_load(1, 1, 3, 3, 16'd40);
    lookup(1, 13, 3, 0, 0);
    wait_idle(1);
    chk("tok_oob_b0", cap_data[1][0], 32'h0014_000A);
    chk("tok_oob_b1", cap_data[1][1], 32'h0028_001E);
    chk("tok_oob_flag", {30'd0, cap_oob[1][0], cap_oob[1][1]}, 32'd3);
    lookup(1, 2, 7, 0, 0);
    wait_idle(1);
    chk("pos_oob_b0", cap_data[1][0], 32'h00C8_0064);
    chk("pos_oob_b1", cap_data[1][1], 32'h0190_012C);
    chk("pos_oob_flag", {30'd0, cap_oob[1][0], cap_oob[1][1]}, 32'd3);
    lookup(1, 2, 6, 0, 0);
    wait_idle(1);
    chk("pos_edge_oob", 32'(cap_oob[1][0]), 1);
    lookup(1, 11, 5, 0, 0);
    wait_idle(1);
    chk("in_range_oob", 32'(cap_oob[1][0]), 0);

    // Reset while beat 0 is stalled.
    lookup(0, 0, 0, 1, 0);
    wait_idle(0);
    d_out_ready[0] = 1'b0;
    lookup(0, 5, 2, 0, 0);
    @(posedge clk); #1;
    chk("mid_valid", 32'(ifa.out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(ifb.in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    chk("mid_rst_valid", 32'(ifa.out_valid), 0);
    chk("mid_rst_cnt", 32'(ifa.pos_cnt), 0);
    chk("mid_rst_data", ifa.out_data, 0);
    d_out_ready[0] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("mid_no_beats", 32'(ifa.out_valid), 0);
    lookup(0, 5, 2, 0, 0);
    wait_idle(0);
    chk("post_rst_b0", cap_data[0][0], 0);
    chk("post_rst_b1", cap_data[0][1], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
`default_nettype wire
